// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Funct3 encodings, FSM states, lane/format helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_t;

  // Stores share the load width encodings.
  localparam funct3_t F3_SB = F3_LB;
  localparam funct3_t F3_SH = F3_LH;
  localparam funct3_t F3_SW = F3_LW;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } lsu_state_t;

  // Width comes from f3[1:0]; 11 and above fall back to word.
  function automatic logic [3:0] lane_mask(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'hF;
    unique case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'hF;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (f3[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = off[0];
      default: m = |off;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_data(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    logic [31:0] d;
    d = wd;
    unique case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_fmt(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    r = w;
    unique case (f3[1:0])
      2'b00: r = f3[2] ? {24'h0, b}
                       : {{24{b[7]}}, b};
      2'b01: r = f3[2] ? {16'h0, h}
                       : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// Core <-> LSU memory-access bundle.
// master = core datapath, slave = lsu_dmem.
interface lsu_dmem_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Misaligned;
  logic        Fault;

  modport master (
    output MemRead,
    output MemWrite,
    output Funct3,
    output Addr,
    output WriteData,
    input  ReadData,
    input  Stall,
    input  Misaligned,
    input  Fault
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  Funct3,
    input  Addr,
    input  WriteData,
    output ReadData,
    output Stall,
    output Misaligned,
    output Fault
  );
endinterface

// File: rtl/dmem_sram.sv
// Word-wide data SRAM, byte write enables, registered read.
// Ports: clk, i_re, i_we[3:0], i_addr, i_wdata, o_rdata.
module dmem_sram #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/lsu_dmem.sv
// RV32I load/store unit with wait-stated data memory.
// Ports: clk, reset (async, low), bus (lsu_dmem_if.slave).
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic       clk,
  input logic       reset,
  lsu_dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW =
    (WAIT_STATES > 2) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(WAIT_STATES - 1);

  lsu_state_t    r_state;
  lsu_state_t    w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [31:0]   r_word;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;

  logic [31:0] w_q;
  logic [31:0] w_word;
  logic [31:0] w_wdata;
  logic [3:0]  w_we;
  logic        w_both;
  logic        w_req;
  logic        w_mis;
  logic        w_oor;
  logic        w_idle;
  logic        w_ok;
  logic        w_ld;
  logic        w_st;
  logic        w_issue;
  logic        w_cap;

  assign w_both = bus.MemRead & bus.MemWrite;
  assign w_req  = bus.MemRead | bus.MemWrite;
  assign w_mis  = misaligned(bus.Funct3,
                             bus.Addr[1:0]);
  assign w_oor  = |bus.Addr[31:AW+2];
  assign w_idle = (r_state == IDLE);

  // Only a clean single-strobe access in IDLE
  // touches the memory.
  assign w_ok = w_idle & w_req & ~w_both
              & ~w_mis & ~w_oor;
  assign w_ld = w_ok & bus.MemRead;
  assign w_st = w_ok & bus.MemWrite;

  assign w_we = w_st
              ? lane_mask(bus.Funct3, bus.Addr[1:0])
              : 4'b0000;
  assign w_wdata = store_data(bus.Funct3,
                              bus.WriteData);

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk    (clk),
    .i_re   (w_issue),
    .i_we   (w_we),
    .i_addr (bus.Addr[AW+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_q)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_issue    = 1'b0;
    w_cap      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ld) begin
          w_issue  = 1'b1;
          w_cnt_nx = CNT_INIT;
          w_state_nx =
            (WAIT_STATES == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        // Counter hits zero on this edge: the
        // SRAM word has been valid since the
        // first WAIT cycle, so grab it now.
        w_cnt_nx = r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) begin
          w_cap      = 1'b1;
          w_state_nx = DONE;
        end
      end
      DONE: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_f3    <= '0;
      r_off   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_cap) begin
        r_word <= w_q;
      end
      if (w_issue) begin
        r_f3  <= bus.Funct3;
        r_off <= bus.Addr[1:0];
      end
    end
  end

  // With a single wait state DONE follows the
  // issue edge directly, so the SRAM output
  // register is the captured word.
  always_comb begin
    w_word = r_word;
    if (WAIT_STATES == 1) begin
      w_word = w_q;
    end
  end

  assign bus.ReadData = (r_state == DONE)
                      ? load_fmt(w_word, r_f3, r_off)
                      : 32'h0;

  // Flags and stall follow the inputs in IDLE,
  // so force them low while reset is held.
  assign bus.Stall = reset
                   & ((w_idle & w_ld)
                   | (r_state == WAIT));
  assign bus.Misaligned = reset & w_idle
                        & w_req & w_mis;
  assign bus.Fault = reset & w_idle
                   & (w_both | (w_req & w_oor));

endmodule

// File: tb/tb_lsu_dmem.sv
// Self-checking bench for lsu_dmem.
// Two DUTs: 1024 words/1 wait, 256 words/3 waits.
module tb_lsu_dmem;
  import lsu_pkg::*;

  localparam int D0 = 1024;
  localparam int W0 = 1;
  localparam int D1 = 256;
  localparam int W1 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_dmem_if bus0();
  lsu_dmem_if bus1();

  lsu_dmem #(.DEPTH_WORDS(D0), .WAIT_STATES(W0))
  u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

  lsu_dmem #(.DEPTH_WORDS(D1), .WAIT_STATES(W1))
  u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  logic [7:0] bm [longint];

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    int          sel;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        emi;
    logic        efa;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input string n, input logic rd,
    input logic wr, input logic [2:0] f3,
    input int sel, input logic [31:0] a,
    input logic [31:0] wd, input logic [31:0] erd,
    input logic emi, input logic efa);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.f3 = f3;
    v.sel = sel; v.a = a; v.wd = wd; v.erd = erd;
    v.emi = emi; v.efa = efa;
    return v;
  endfunction

  function automatic int depth_of(input int d);
    return (d != 0) ? D1 : D0;
  endfunction

  function automatic int wait_of(input int d);
    return (d != 0) ? W1 : W0;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic set_in(input int d,
    input logic rd, input logic wr,
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd);
    if (d == 0) begin
      bus0.MemRead = rd; bus0.MemWrite = wr;
      bus0.Funct3 = f3; bus0.Addr = a;
      bus0.WriteData = wd;
    end else begin
      bus1.MemRead = rd; bus1.MemWrite = wr;
      bus1.Funct3 = f3; bus1.Addr = a;
      bus1.WriteData = wd;
    end
  endtask

  task automatic get_out(input int d,
    output logic [31:0] rdv, output logic st,
    output logic mi, output logic fa);
    if (d == 0) begin
      rdv = bus0.ReadData; st = bus0.Stall;
      mi = bus0.Misaligned; fa = bus0.Fault;
    end else begin
      rdv = bus1.ReadData; st = bus1.Stall;
      mi = bus1.Misaligned; fa = bus1.Fault;
    end
  endtask

  // Apply one access starting just after a rising
  // edge; returns flags of the request cycle, the
  // number of stalled cycles and ReadData of the
  // first non-stalled cycle.
  task automatic access(input int d,
    input logic rd, input logic wr,
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd,
    output logic [31:0] rdv, output int nst,
    output logic mi, output logic fa);
    logic st, m2, f2;
    set_in(d, rd, wr, f3, a, wd);
    @(negedge clk);
    get_out(d, rdv, st, mi, fa);
    nst = 0;
    while (st && nst < 16) begin
      nst++;
      @(posedge clk);
      @(negedge clk);
      get_out(d, rdv, st, m2, f2);
    end
    if (st) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout d=%0d a=%h", d, a);
    end
    @(posedge clk);
    #1;
    set_in(d, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
  endtask

  function automatic longint key(input int d,
                                 input logic [31:0] a);
    return longint'({d[31:0], a});
  endfunction

  function automatic logic [7:0] rd_byte(
    input int d, input logic [31:0] a);
    if (bm.exists(key(d, a))) return bm[key(d, a)];
    return 8'h00;
  endfunction

  // Byte-addressed reference: little-endian bytes,
  // natural alignment, word-range check.
  function automatic void model(input int d,
    input logic rd, input logic wr,
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd,
    output logic [31:0] erd, output int est,
    output logic emi, output logic efa);
    int w;
    logic req, ok;
    logic [31:0] v;
    w = (f3[1:0] == 2'b00) ? 1
      : (f3[1:0] == 2'b01) ? 2 : 4;
    req = rd | wr;
    emi = req && ((a & 32'(w - 1)) != 0);
    efa = (rd && wr) ||
          (req && ((a >> 2) >= 32'(depth_of(d))));
    erd = 32'h0;
    est = 0;
    ok = req && !emi && !efa;
    if (ok && wr) begin
      for (int i = 0; i < w; i++)
        bm[key(d, a + 32'(i))] = wd[8*i +: 8];
    end
    if (ok && rd) begin
      v = 32'h0;
      for (int i = 0; i < w; i++)
        v[8*i +: 8] = rd_byte(d, a + 32'(i));
      if (!f3[2] && w == 1)
        v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && w == 2)
        v = {{16{v[15]}}, v[15:0]};
      erd = v;
      est = wait_of(d);
    end
  endfunction

  task automatic run_op(input string nm, input int d,
    input logic rd, input logic wr,
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd);
    logic [31:0] erd, ard;
    int est, ast;
    logic emi, efa, ami, afa;
    model(d, rd, wr, f3, a, wd, erd, est, emi, efa);
    access(d, rd, wr, f3, a, wd, ard, ast, ami, afa);
    chk($sformatf("%s_d%0d_a%h_rdata", nm, d, a), ard, erd);
    chk($sformatf("%s_d%0d_a%h_stall", nm, d, a),
        32'(ast), 32'(est));
    chk($sformatf("%s_d%0d_a%h_mis", nm, d, a),
        32'(ami), 32'(emi));
    chk($sformatf("%s_d%0d_a%h_fault", nm, d, a),
        32'(afa), 32'(efa));
  endtask

  initial begin : main
    logic [31:0] rdv, a;
    logic st, mi, fa;
    int nst, est, r;
    logic rd, wr;

    set_in(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    set_in(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      get_out(d, rdv, st, mi, fa);
      chk($sformatf("rst_d%0d_rdata", d), rdv, 32'h0);
      chk($sformatf("rst_d%0d_stall", d), 32'(st), 32'h0);
      chk($sformatf("rst_d%0d_mis", d), 32'(mi), 32'h0);
      chk($sformatf("rst_d%0d_fault", d), 32'(fa), 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // sel: 0 = use a, 1 = depth*4, 2 = last word
    tv.push_back(mk("sw0", 0, 1, F3_SW, 0, 32'h00,
      32'h01020304, 32'h0, 0, 0));
    tv.push_back(mk("sw10", 0, 1, F3_SW, 0, 32'h10,
      32'hDEADBEEF, 32'h0, 0, 0));
    tv.push_back(mk("sb11", 0, 1, F3_SB, 0, 32'h11,
      32'hAAAAAA55, 32'h0, 0, 0));
    tv.push_back(mk("lw10", 1, 0, F3_LW, 0, 32'h10,
      32'h0, 32'hDEAD55EF, 0, 0));
    tv.push_back(mk("sw20", 0, 1, F3_SW, 0, 32'h20,
      32'h80F07F81, 32'h0, 0, 0));
    tv.push_back(mk("lb20", 1, 0, F3_LB, 0, 32'h20,
      32'h0, 32'hFFFFFF81, 0, 0));
    tv.push_back(mk("lbu20", 1, 0, F3_LBU, 0, 32'h20,
      32'h0, 32'h00000081, 0, 0));
    tv.push_back(mk("lh22", 1, 0, F3_LH, 0, 32'h22,
      32'h0, 32'hFFFF80F0, 0, 0));
    tv.push_back(mk("lhu22", 1, 0, F3_LHU, 0, 32'h22,
      32'h0, 32'h000080F0, 0, 0));
    tv.push_back(mk("lw21", 1, 0, F3_LW, 0, 32'h21,
      32'h0, 32'h0, 1, 0));
    tv.push_back(mk("sh23", 0, 1, F3_SH, 0, 32'h23,
      32'h0000FFFF, 32'h0, 1, 0));
    tv.push_back(mk("lw20", 1, 0, F3_LW, 0, 32'h20,
      32'h0, 32'h80F07F81, 0, 0));
    tv.push_back(mk("sw_oor", 0, 1, F3_SW, 1, 32'h0,
      32'h11111111, 32'h0, 0, 1));
    tv.push_back(mk("lw0", 1, 0, F3_LW, 0, 32'h00,
      32'h0, 32'h01020304, 0, 0));
    tv.push_back(mk("lw_oor", 1, 0, F3_LW, 1, 32'h0,
      32'h0, 32'h0, 0, 1));
    tv.push_back(mk("lb_hi", 1, 0, F3_LB, 0, 32'h80000020,
      32'h0, 32'h0, 0, 1));
    tv.push_back(mk("sw_last", 0, 1, F3_SW, 2, 32'h0,
      32'hCAFEF00D, 32'h0, 0, 0));
    tv.push_back(mk("lw_last", 1, 0, F3_LW, 2, 32'h0,
      32'h0, 32'hCAFEF00D, 0, 0));
    tv.push_back(mk("both", 1, 1, F3_SW, 0, 32'h20,
      32'h0, 32'h0, 0, 1));
    tv.push_back(mk("lw20b", 1, 0, F3_LW, 0, 32'h20,
      32'h0, 32'h80F07F81, 0, 0));
    tv.push_back(mk("sh12", 0, 1, F3_SH, 0, 32'h12,
      32'hABCD1234, 32'h0, 0, 0));
    tv.push_back(mk("lw10b", 1, 0, F3_LW, 0, 32'h10,
      32'h0, 32'h123455EF, 0, 0));
    tv.push_back(mk("lh10", 1, 0, F3_LH, 0, 32'h10,
      32'h0, 32'h000055EF, 0, 0));
    tv.push_back(mk("lb13", 1, 0, F3_LB, 0, 32'h13,
      32'h0, 32'h00000012, 0, 0));
    tv.push_back(mk("lb10", 1, 0, F3_LB, 0, 32'h10,
      32'h0, 32'hFFFFFFEF, 0, 0));
    tv.push_back(mk("lbu11", 1, 0, F3_LBU, 0, 32'h11,
      32'h0, 32'h00000055, 0, 0));
    tv.push_back(mk("lh21", 1, 0, F3_LH, 0, 32'h21,
      32'h0, 32'h0, 1, 0));
    tv.push_back(mk("f3_011", 1, 0, 3'b011, 0, 32'h20,
      32'h0, 32'h80F07F81, 0, 0));
    tv.push_back(mk("f3_111", 1, 0, 3'b111, 0, 32'h22,
      32'h0, 32'h0, 1, 0));
    tv.push_back(mk("f3_110", 1, 0, 3'b110, 0, 32'h10,
      32'h0, 32'h123455EF, 0, 0));

    for (int d = 0; d < 2; d++) begin
      foreach (tv[i]) begin
        a = tv[i].a;
        if (tv[i].sel == 1) a = 32'(depth_of(d) * 4);
        if (tv[i].sel == 2) a = 32'(depth_of(d) * 4 - 4);
        est = (tv[i].rd && !tv[i].wr && !tv[i].emi &&
               !tv[i].efa) ? wait_of(d) : 0;
        access(d, tv[i].rd, tv[i].wr, tv[i].f3, a,
               tv[i].wd, rdv, nst, mi, fa);
        chk($sformatf("%s_d%0d_rdata", tv[i].name, d),
            rdv, tv[i].erd);
        chk($sformatf("%s_d%0d_stall", tv[i].name, d),
            32'(nst), 32'(est));
        chk($sformatf("%s_d%0d_mis", tv[i].name, d),
            32'(mi), 32'(tv[i].emi));
        chk($sformatf("%s_d%0d_fault", tv[i].name, d),
            32'(fa), 32'(tv[i].efa));
      end
    end

    // Reset in the middle of a 3-wait-state load.
    access(1, 1'b0, 1'b1, F3_SW, 32'h40, 32'h5A5AA5A5,
           rdv, nst, mi, fa);
    set_in(1, 1'b1, 1'b0, F3_LW, 32'h40, 32'h0);
    @(negedge clk);
    get_out(1, rdv, st, mi, fa);
    chk("rml_req_stall", 32'(st), 32'h1);
    @(posedge clk);
    @(negedge clk);
    get_out(1, rdv, st, mi, fa);
    chk("rml_wait_stall", 32'(st), 32'h1);
    chk("rml_wait_rdata", rdv, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    get_out(1, rdv, st, mi, fa);
    chk("rml_rst_stall", 32'(st), 32'h0);
    chk("rml_rst_rdata", rdv, 32'h0);
    chk("rml_rst_fault", 32'(fa), 32'h0);
    set_in(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    access(1, 1'b1, 1'b0, F3_LW, 32'h40, 32'h0,
           rdv, nst, mi, fa);
    chk("rml_after_rdata", rdv, 32'h5A5AA5A5);
    chk("rml_after_stall", 32'(nst), 32'(W1));
    access(1, 1'b1, 1'b0, F3_LW, 32'h20, 32'h0,
           rdv, nst, mi, fa);
    chk("rml_after_lw20", rdv, 32'h80F07F81);

    // Randomized traffic against the byte model.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++)
        run_op("fill", d, 1'b0, 1'b1, F3_SW,
               32'h100 + 32'(4 * k), $urandom);
      for (int k = 0; k < 200; k++) begin
        r = $urandom_range(0, 9);
        rd = (r < 4) || (r == 8);
        wr = (r >= 4 && r < 8) || (r == 8);
        a = 32'h100 + 32'($urandom_range(0, 63));
        if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 1) == 0)
            a = 32'(depth_of(d) * 4) +
                32'($urandom_range(0, 255));
          else
            a = 32'h80000000 | 32'($urandom);
        end
        run_op("rnd", d, rd, wr,
               3'($urandom_range(0, 7)), a, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_dmem.md
# lsu_dmem

Load/store unit and data memory for the single-cycle RV32I core. It sits directly downstream of the datapath. It consumes the ALU result as the address, the register-file write data and the memory control strobes. It returns the formatted load data to the result mux. Stores complete in one cycle. Loads use a synchronous memory with a configurable number of wait states and hold the core with `Stall`.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: memory depth in 32-bit words. Must be a power of two.
- `WAIT_STATES`, default 1: load latency in cycles, minimum 1. A load occupies `WAIT_STATES+1` cycles.

Ports:
- `clk`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. `reset=0` clears all state immediately.
- `MemRead`  in  1  load request for the current instruction.
- `MemWrite`  in  1  store request for the current instruction.
- `Funct3`  in  3  access width and sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- `Addr`  in  32  byte address, taken from `ALUResult`.
- `WriteData`  in  32  store data. The low byte or halfword is used for sb/sh.
- `ReadData`  out  32  sign- or zero-extended load result.
- `Stall`  out  1  high while a load is outstanding. The core gates its PC register with `~Stall`.
- `Misaligned`  out  1  the current access violates natural alignment.
- `Fault`  out  1  the current access is out of range, or `MemRead` and `MemWrite` are both high.

## Operation
State machine: IDLE, WAIT, DONE.
- **IDLE:**
  - Valid store: byte-lane write at the rising edge. `Stall=0`. Stay in IDLE.
  - Valid load: `Stall=1` combinationally. Issue the word read at the edge. Load the wait counter with `WAIT_STATES-1`. Go to WAIT, or straight to DONE when `WAIT_STATES=1`.
- **WAIT:**
  - `Stall=1`.
  - The counter decrements each cycle. At 0, capture the memory word and go to DONE.
- **DONE:**
  - `Stall=0`.
  - `ReadData` is driven from the captured word, extended per `Funct3`. The core writes back and advances at the end of this cycle.
  - Next state is always IDLE. The load is never re-issued.
- **Byte lanes:**
  - sb: enable lane `Addr[1:0]`.
  - sh: enable lanes `{Addr[1],1}` and `{Addr[1],0}`.
  - sw: enable all four lanes.
  - Store data is replicated across lanes.
- **Load extraction:** same lane selection as stores. lb and lh sign-extend from bit 7 or bit 15. lbu and lhu zero-extend.
- **Misaligned:** lh, lhu or sh with `Addr[0]=1`; lw or sw with `Addr[1:0]≠0`.
- **Range fault:** `Addr[31:2] >= DEPTH_WORDS`, or `Addr[31:2+log2(DEPTH_WORDS)]` nonzero.
- **Misaligned or faulting access:**
  - No write is performed and no stall occurs.
  - `ReadData=0`.
  - The flag is high for that cycle, combinational from the inputs, in IDLE only.
- **Illegal strobes:** `MemRead` and `MemWrite` both high gives `Fault=1` and no access.
- **Unlisted Funct3:** treated as lw/sw for alignment checks and width.
- **Inputs during a load:** ignored in WAIT and DONE. The core holds them stable because its PC is frozen.

## Timing
- **Reset values:** state IDLE, counter 0, captured word 0, `ReadData=0`, `Stall=0`, `Misaligned=0`, `Fault=0`.
- **Memory array:** not cleared by reset.
- **Reset mid-load:** returns to IDLE immediately. `Stall` drops asynchronously and the captured data is discarded.
- **Store latency:** 0 extra cycles. Data is visible to a load issued in the next cycle.
- **Load latency:** `Stall` is high for exactly `WAIT_STATES` cycles, starting in the request cycle. `ReadData` is valid in the single DONE cycle.
- **Back-to-back loads:** a load in the cycle after DONE starts a new sequence. There is no idle gap beyond the return to IDLE.
- **Outputs:** `ReadData` is combinational from the captured word and `Funct3`. It is 0 outside DONE, except that it is also 0 for a faulting access.

## Structure
Package `lsu_pkg` holds:
- `funct3_t` enum with the LB, LH, LW, LBU, LHU, SB, SH, SW encodings.
- `lsu_state_t` enum: IDLE, WAIT, DONE.
- Lane-mask helper function.

Sub-module `dmem_sram`:
- `DEPTH_WORDS` × 32 array.
- 4-bit byte write enable.
- Registered read port with 1-cycle latency; the FSM adds the remaining wait states.
- No reset on the array.

Remaining logic: the top-level FSM, the wait counter, the alignment/range check and the load formatter.

## Test plan
- **Byte store and word load:** sw 0xDEADBEEF at 0x10, then sb 0x55 at 0x11, then lw at 0x10. Expect `ReadData=0xDEAD55EF` in DONE, with `Stall` high for `WAIT_STATES` cycles.
- **Sign extension:** memory word 0x80F07F81 at 0x20.
  - lb 0x20 gives 0xFFFFFF81.
  - lbu 0x20 gives 0x00000081.
  - lh 0x22 gives 0xFFFF80F0.
  - lhu 0x22 gives 0x000080F0.
- **Misalignment:** lw 0x21 and sh 0x23 give `Misaligned=1`, `Stall=0`, and memory unchanged. A following lw 0x20 still returns 0x80F07F81.
- **Range and strobe faults:** `Addr=DEPTH_WORDS*4` gives `Fault=1` with no write. `MemRead=MemWrite=1` gives `Fault=1` with no access.
- **Wait states:** with `WAIT_STATES=3`, a load gives `Stall=1` for 3 cycles, DONE on cycle 4 and IDLE on cycle 5. Back-to-back loads return correct data each time.
- **Reset mid-load:** assert `reset=0` in WAIT. Expect `Stall=0` and `ReadData=0` immediately. After release the FSM is in IDLE, and previously stored data is still readable.
